// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray-code counter with registered binary and Gray outputs.
// Define GRAY_CNT_CHECK_EN to add the sticky Gray-adjacency error flag (err).
module gray_counter_param #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc,
`ifdef GRAY_CNT_CHECK_EN
  output logic             wrap,
  output logic             err
`else
  output logic             wrap
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] grayToBin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic [WIDTH-1:0] w_nextBin;
  logic [WIDTH-1:0] w_nextGray;
  logic             w_nextWrap;

  // Load beats a step; a saturating counter at a limit simply holds.
  always_comb begin
    w_nextBin  = r_bin;
    w_nextWrap = 1'b0;
    if (load) begin
      w_nextBin = grayToBin(load_gray);
    end else if (enable) begin
      if (up_down) begin
        if (r_bin != MAX_VAL) begin
          w_nextBin = r_bin + ONE;
        end else if (!SATURATE) begin
          w_nextBin  = '0;
          w_nextWrap = 1'b1;
        end
      end else begin
        if (r_bin != '0) begin
          w_nextBin = r_bin - ONE;
        end else if (!SATURATE) begin
          w_nextBin  = MAX_VAL;
          w_nextWrap = 1'b1;
        end
      end
    end
  end

  assign w_nextGray = w_nextBin ^ (w_nextBin >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_nextBin;
      r_gray <= w_nextGray;
      r_wrap <= w_nextWrap;
    end
  end

  assign bin_out  = r_bin;
  assign gray_out = r_gray;
  assign wrap     = r_wrap;
  assign tc       = up_down ? (r_bin == MAX_VAL) : (r_bin == '0);

`ifdef GRAY_CNT_CHECK_EN
  logic [WIDTH-1:0] r_prevGray;
  logic             r_wasLoad;
  logic             r_err;
  logic [WIDTH-1:0] w_grayDiff;
  logic             w_multiBit;

  assign w_grayDiff = r_gray ^ r_prevGray;
  assign w_multiBit = (w_grayDiff & (w_grayDiff - ONE)) != '0;

  // r_wasLoad marks transitions caused by a load, which may jump arbitrarily.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prevGray <= '0;
      r_wasLoad  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_prevGray <= r_gray;
      r_wasLoad  <= load;
      if (w_multiBit && !r_wasLoad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_gray_counter_param.sv
// Scoreboard bench for gray_counter_param: three instances (8-bit wrap, 8-bit saturate, 4-bit wrap).
// Define GRAY_CNT_CHECK_EN to also exercise the adjacency checker.
module tb_gray_counter_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       upDown = 1'b1;
  logic       load = 1'b0;
  logic [7:0] loadGray = 8'h00;

  logic [7:0] bin8, gray8, binSat, graySat;
  logic [3:0] bin4, gray4;
  logic       tc8, wrap8, tcSat, wrapSat, tc4, wrap4;
`ifdef GRAY_CNT_CHECK_EN
  logic       err8, errSat, err4;
`endif

  always #5 clk = ~clk;

  gray_counter_param #(.WIDTH(8), .SATURATE(1'b0)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .up_down(upDown), .load(load),
    .load_gray(loadGray), .bin_out(bin8), .gray_out(gray8), .tc(tc8),
`ifdef GRAY_CNT_CHECK_EN
    .wrap(wrap8), .err(err8)
`else
    .wrap(wrap8)
`endif
  );

  gray_counter_param #(.WIDTH(8), .SATURATE(1'b1)) dutSat (
    .clk(clk), .reset(reset), .enable(enable), .up_down(upDown), .load(load),
    .load_gray(loadGray), .bin_out(binSat), .gray_out(graySat), .tc(tcSat),
`ifdef GRAY_CNT_CHECK_EN
    .wrap(wrapSat), .err(errSat)
`else
    .wrap(wrapSat)
`endif
  );

  gray_counter_param #(.WIDTH(4), .SATURATE(1'b0)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .up_down(upDown), .load(load),
    .load_gray(loadGray[3:0]), .bin_out(bin4), .gray_out(gray4), .tc(tc4),
`ifdef GRAY_CNT_CHECK_EN
    .wrap(wrap4), .err(err4)
`else
    .wrap(wrap4)
`endif
  );

  typedef struct {
    int         dutId;
    logic [7:0] bin;
    logic [7:0] gray;
    logic       wrap;
    logic       tc;
    logic       err;
    bit         chkMain;
    bit         chkErr;
    string      name;
  } expRec_t;

  expRec_t expQ[$];
  int passCount = 0;
  int checkCount = 0;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic pushExpect(input int id, input logic [7:0] eBin, input logic [7:0] eGray,
                            input logic eWrap, input logic eTc, input logic eErr,
                            input bit cMain, input bit cErr, input string name);
    expRec_t r;
    r.dutId = id; r.bin = eBin; r.gray = eGray; r.wrap = eWrap; r.tc = eTc;
    r.err = eErr; r.chkMain = cMain; r.chkErr = cErr; r.name = name;
    expQ.push_back(r);
  endtask

  // Drive one cycle of inputs, queue the expectation after the edge, then let the monitor sample.
  task automatic applyStimulus(input logic rst, input logic en, input logic ud, input logic ld,
                               input logic [7:0] lg, input int id,
                               input logic [7:0] eBin, input logic [7:0] eGray,
                               input logic eWrap, input logic eTc, input string name);
    reset = rst; enable = en; upDown = ud; load = ld; loadGray = lg;
    @(posedge clk); #1;
    pushExpect(id, eBin, eGray, eWrap, eTc, 1'b0, 1'b1, 1'b1, name);
    @(negedge clk); #1;
  endtask

  expRec_t    monRec;
  logic [7:0] aBin, aGray;
  logic       aWrap, aTc;
`ifdef GRAY_CNT_CHECK_EN
  logic       aErr;
`endif

  // Monitor: pops one expectation per cycle and compares it with the selected instance.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monRec = expQ.pop_front();
      case (monRec.dutId)
        0: begin aBin = bin8; aGray = gray8; aWrap = wrap8; aTc = tc8; end
        1: begin aBin = binSat; aGray = graySat; aWrap = wrapSat; aTc = tcSat; end
        default: begin aBin = {4'h0, bin4}; aGray = {4'h0, gray4}; aWrap = wrap4; aTc = tc4; end
      endcase
      if (monRec.chkMain) begin
        checkOutput({monRec.name, ".bin"}, aBin, monRec.bin);
        checkOutput({monRec.name, ".gray"}, aGray, monRec.gray);
        checkOutput({monRec.name, ".wrap"}, {7'h0, aWrap}, {7'h0, monRec.wrap});
        checkOutput({monRec.name, ".tc"}, {7'h0, aTc}, {7'h0, monRec.tc});
      end
`ifdef GRAY_CNT_CHECK_EN
      case (monRec.dutId)
        0: aErr = err8;
        1: aErr = errSat;
        default: aErr = err4;
      endcase
      if (monRec.chkErr) checkOutput({monRec.name, ".err"}, {7'h0, aErr}, {7'h0, monRec.err});
`endif
    end
  end

  logic [7:0] grayTbl [5] = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07};

  initial begin
    int         mBin;
    logic [7:0] eb;
    logic       w;

    @(negedge clk); #1;

    // Reset state, tc following up_down
    applyStimulus(1, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, "reset8");
    applyStimulus(1, 0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 1, "resetDownTc");

    for (int k = 1; k <= 5; k++)
      applyStimulus(0, 1, 1, 0, 8'h00, 0, 8'(k), grayTbl[k-1], 0, 0, "upCount");

    applyStimulus(0, 0, 1, 1, 8'h80, 0, 8'hFF, 8'h80, 0, 1, "load80");
    applyStimulus(0, 1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, "upWrap");
    applyStimulus(0, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, "wrapPulseEnd");

    applyStimulus(1, 0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 1, "satReset");
    for (int k = 0; k < 3; k++)
      applyStimulus(0, 1, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 1, "downSat");
    applyStimulus(0, 0, 1, 1, 8'h80, 1, 8'hFF, 8'h80, 0, 1, "satLoad");
    applyStimulus(0, 1, 1, 0, 8'h00, 1, 8'hFF, 8'h80, 0, 1, "upSat");

    applyStimulus(0, 1, 1, 1, 8'h07, 0, 8'h05, 8'h07, 0, 0, "loadBeatsEnable");
    applyStimulus(1, 1, 1, 1, 8'h07, 0, 8'h00, 8'h00, 0, 0, "resetBeatsLoad");
    // Direction change with back-to-back wraps
    applyStimulus(0, 1, 0, 0, 8'h00, 0, 8'hFF, 8'h80, 1, 0, "downWrap");
    applyStimulus(0, 1, 1, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, "upWrapAgain");

    applyStimulus(1, 0, 1, 0, 8'h00, 2, 8'h00, 8'h00, 0, 0, "reset4");
    mBin = 0;
    for (int k = 1; k <= 40; k++) begin
      w = (mBin == 15);
      mBin = (mBin + 1) % 16;
      eb = 8'(mBin);
      applyStimulus(0, 1, 1, 0, 8'h00, 2, eb, eb ^ (eb >> 1), w, (mBin == 15), "sweepUp");
    end
    for (int k = 1; k <= 40; k++) begin
      w = (mBin == 0);
      mBin = (mBin + 15) % 16;
      eb = 8'(mBin);
      applyStimulus(0, 1, 0, 0, 8'h00, 2, eb, eb ^ (eb >> 1), w, (mBin == 0), "sweepDown");
    end

`ifdef GRAY_CNT_CHECK_EN
    applyStimulus(1, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, "chkReset");
    reset = 0; enable = 0; upDown = 1; load = 0;
    force dut8.r_gray = 8'h03;
    @(posedge clk); #1;
    release dut8.r_gray;
    pushExpect(0, 8'h00, 8'h00, 0, 0, 1'b1, 1'b0, 1'b1, "errSet");
    @(negedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      reset = 0; enable = 0; upDown = 1; load = 0;
      @(posedge clk); #1;
      pushExpect(0, 8'h00, 8'h00, 0, 0, 1'b1, 1'b0, 1'b1, "errSticky");
      @(negedge clk); #1;
    end
    applyStimulus(1, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, "errClear");
`endif

    reset = 0; enable = 0; load = 0;
    for (int i = 0; i < 4 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      checkCount++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
